// File: rtl/rv32im_mul_pkg.sv
// Shared RV32IM execute-stage definitions: multiply and divide op encodings (funct3[1:0]).
package rv32im_mul_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    localparam logic [1:0] OP_DIV    = 2'b00;
    localparam logic [1:0] OP_DIVU   = 2'b01;
    localparam logic [1:0] OP_REM    = 2'b10;
    localparam logic [1:0] OP_REMU   = 2'b11;

endpackage

// File: rtl/rv32im_mul.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operates on magnitudes and applies the sign to the full 2W-bit product at completion.
module rv32im_mul
    import rv32im_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q,   busy_d;
    logic             valid_q,  valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] ma_q,     ma_d;
    logic [WIDTH-1:0] mq_q,     mq_d;
    logic [WIDTH:0]   acc_q,    acc_d;
    logic [CW-1:0]    i_q,      i_d;
    logic             neg_q,    neg_d;
    logic             sel_hi_q, sel_hi_d;

    logic               x_neg, y_neg;
    logic [WIDTH-1:0]   x_mag, y_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod, prod_fin;

    // Only signed-and-negative operands are converted; -MIN wraps to MIN, which is its unsigned magnitude.
    assign x_neg = ((op == OP_MULH) || (op == OP_MULHSU)) && x[WIDTH-1];
    assign y_neg = (op == OP_MULH) && y[WIDTH-1];
    assign x_mag = x_neg ? -x : x;
    assign y_mag = y_neg ? -y : y;

    assign sum      = acc_q + {1'b0, (mq_q[0] ? ma_q : '0)};
    assign prod     = {sum, mq_q[WIDTH-1:1]};
    assign prod_fin = neg_q ? -prod : prod;

    always_comb begin
        busy_d   = busy_q;
        valid_d  = 1'b0;
        result_d = result_q;
        ma_d     = ma_q;
        mq_d     = mq_q;
        acc_d    = acc_q;
        i_d      = i_q;
        neg_d    = neg_q;
        sel_hi_d = sel_hi_q;

        if (start) begin
            neg_d    = x_neg ^ y_neg;
            ma_d     = x_mag;
            mq_d     = y_mag;
            acc_d    = '0;
            i_d      = '0;
            sel_hi_d = (op != OP_MUL);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            {acc_d, mq_d} = {1'b0, sum, mq_q[WIDTH-1:1]};
            i_d           = i_q + CW'(1);
            if (i_q == CW'(WIDTH - 1)) begin
                result_d = sel_hi_q ? prod_fin[2*WIDTH-1:WIDTH] : prod_fin[WIDTH-1:0];
                busy_d   = 1'b0;
                valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            ma_q     <= '0;
            mq_q     <= '0;
            acc_q    <= '0;
            i_q      <= '0;
            neg_q    <= 1'b0;
            sel_hi_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            ma_q     <= ma_d;
            mq_q     <= mq_d;
            acc_q    <= acc_d;
            i_q      <= i_d;
            neg_q    <= neg_d;
            sel_hi_q <= sel_hi_d;
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign result = result_q;

endmodule
